// File: rtl/mult_sequencer_if.sv
// rtl/mult_sequencer_if.sv - handshake and control-word bundle between pins, sequencer and datapath
interface mult_sequencer_if;
  logic       start;
  logic       abort;
  logic       flag;
  logic       busy;
  logic       done;
  logic [2:0] iter;
  logic       en_a;
  logic       en_b;
  logic       en_dpo;
  logic       ab_sel;
  logic [1:0] sr_ctl;
  logic       en_sr;
  logic       sr_sel;
  logic [2:0] alu_op;
  logic       en_acc;
  logic       clr_acc;

  modport master (
    output start, abort, flag,
    input  busy, done, iter, en_a, en_b, en_dpo, ab_sel,
    input  sr_ctl, en_sr, sr_sel, alu_op, en_acc, clr_acc
  );

  modport slave (
    input  start, abort, flag,
    output busy, done, iter, en_a, en_b, en_dpo, ab_sel,
    output sr_ctl, en_sr, sr_sel, alu_op, en_acc, clr_acc
  );
endinterface

// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - shift-add multiply sequencer producing the per-cycle datapath control word
module mult_sequencer #(
  parameter int WIDTH = 4
) (
  input logic           sys_clk,
  input logic           rst_n,
  mult_sequencer_if.slave bus
);

  localparam logic [2:0] LAST = 3'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    LOADSR = 3'd2,
    ADD    = 3'd3,
    SHIFT  = 3'd4,
    STORE  = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [2:0] count;
  logic [2:0] count_nx;

  logic       busy_q;
  logic       done_q;
  logic [2:0] iter_q;
  logic       en_a_q;
  logic       en_b_q;
  logic       en_dpo_q;
  logic       ab_sel_q;
  logic [1:0] sr_ctl_q;
  logic       en_sr_q;
  logic       sr_sel_q;
  logic [2:0] alu_op_q;
  logic       in_add_q;
  logic       clr_acc_q;

  // Next-state and iteration counter; abort overrides every busy state but DONE
  always_comb begin
    state_nx = IDLE;
    count_nx = count;
    case (state)
      IDLE:    state_nx = bus.start ? LOAD : IDLE;
      LOAD: begin
        state_nx = LOADSR;
        count_nx = '0;
      end
      LOADSR:  state_nx = ADD;
      ADD:     state_nx = SHIFT;
      SHIFT: begin
        if (count >= LAST) begin
          state_nx = STORE;
        end else begin
          state_nx = ADD;
          count_nx = count + 3'd1;
        end
      end
      STORE:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.abort && state != IDLE && state != DONE) begin
      state_nx = IDLE;
    end
    if (state_nx == IDLE) begin
      count_nx = '0;
    end
  end

  // State register plus control word registered from the upcoming state, so outputs are glitch-free
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      iter_q    <= '0;
      en_a_q    <= 1'b0;
      en_b_q    <= 1'b0;
      en_dpo_q  <= 1'b0;
      ab_sel_q  <= 1'b0;
      sr_ctl_q  <= 2'b00;
      en_sr_q   <= 1'b0;
      sr_sel_q  <= 1'b0;
      alu_op_q  <= 3'b000;
      in_add_q  <= 1'b0;
      clr_acc_q <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      busy_q    <= (state_nx != IDLE);
      done_q    <= (state_nx == DONE);
      iter_q    <= (state_nx == ADD || state_nx == SHIFT) ? count_nx : 3'd0;
      en_a_q    <= (state_nx == LOAD);
      en_b_q    <= (state_nx == LOAD);
      clr_acc_q <= (state_nx == LOAD);
      en_dpo_q  <= (state_nx == STORE);
      ab_sel_q  <= (state_nx == LOADSR);
      sr_ctl_q  <= (state_nx == LOADSR) ? 2'b10 :
                   (state_nx == SHIFT)  ? 2'b01 : 2'b00;
      en_sr_q   <= (state_nx == LOADSR || state_nx == SHIFT);
      sr_sel_q  <= (state_nx == SHIFT);
      alu_op_q  <= (state_nx == ADD) ? 3'b001 : 3'b000;
      in_add_q  <= (state_nx == ADD);
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.iter    = iter_q;
  assign bus.en_a    = en_a_q;
  assign bus.en_b    = en_b_q;
  assign bus.en_dpo  = en_dpo_q;
  assign bus.ab_sel  = ab_sel_q;
  assign bus.sr_ctl  = sr_ctl_q;
  assign bus.en_sr   = en_sr_q;
  assign bus.sr_sel  = sr_sel_q;
  assign bus.alu_op  = alu_op_q;
  // The accumulator only writes when the multiplier bit in the SR is set
  assign bus.en_acc  = in_add_q & bus.flag;
  assign bus.clr_acc = clr_acc_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - table-driven and sequence checks for mult_sequencer at WIDTH=4
module tb_mult_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_sequencer_if bus();

  mult_sequencer #(.WIDTH(4)) dut (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [2:0] iter;
    logic       en_a;
    logic       en_b;
    logic       en_dpo;
    logic       ab_sel;
    logic [1:0] sr_ctl;
    logic       en_sr;
    logic       sr_sel;
    logic [2:0] alu_op;
    logic       en_acc;
    logic       clr_acc;
  } ctl_t;

  typedef struct {
    logic flag;
    ctl_t exp;
  } row_t;

  row_t tbl[13];
  int   checks   = 0;
  int   failures = 0;
  int   done_cyc, dpo_cyc, extra_loads, cnt;
  int   loads[$];

  localparam ctl_t ZERO = '0;

  function automatic ctl_t mk(int busy, int done, int iter, int en_a, int en_b, int en_dpo,
                              int ab_sel, int sr_ctl, int en_sr, int sr_sel, int alu_op,
                              int en_acc, int clr_acc);
    ctl_t c;
    c.busy    = 1'(busy);
    c.done    = 1'(done);
    c.iter    = 3'(iter);
    c.en_a    = 1'(en_a);
    c.en_b    = 1'(en_b);
    c.en_dpo  = 1'(en_dpo);
    c.ab_sel  = 1'(ab_sel);
    c.sr_ctl  = 2'(sr_ctl);
    c.en_sr   = 1'(en_sr);
    c.sr_sel  = 1'(sr_sel);
    c.alu_op  = 3'(alu_op);
    c.en_acc  = 1'(en_acc);
    c.clr_acc = 1'(clr_acc);
    return c;
  endfunction

  function automatic ctl_t dut_ctl();
    ctl_t c;
    c.busy    = bus.busy;
    c.done    = bus.done;
    c.iter    = bus.iter;
    c.en_a    = bus.en_a;
    c.en_b    = bus.en_b;
    c.en_dpo  = bus.en_dpo;
    c.ab_sel  = bus.ab_sel;
    c.sr_ctl  = bus.sr_ctl;
    c.en_sr   = bus.en_sr;
    c.sr_sel  = bus.sr_sel;
    c.alu_op  = bus.alu_op;
    c.en_acc  = bus.en_acc;
    c.clr_acc = bus.clr_acc;
    return c;
  endfunction

  task automatic chk_ctl(input string nm, input ctl_t act, input ctl_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %05h expected %05h", nm, act, exp);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One start pulse, then 20 cycles of observation; optional re-pulse and abort cycles
  task automatic run_op(input int repulse_at, input int abort_at,
                        output int d_cyc, output int p_cyc, output int extra);
    d_cyc = 0;
    p_cyc = 0;
    extra = 0;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1 && bus.en_a) extra++;
      if (bus.done && d_cyc == 0) d_cyc = c;
      if (bus.en_dpo && p_cyc == 0) p_cyc = c;
      bus.start = (c == repulse_at);
      bus.abort = (c == abort_at);
      cycle();
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    // LOAD..DONE for B=0xD (flags 1,0,1,1 in ADD0..3); flag driven high elsewhere to prove it is ignored
    tbl[0]  = '{1'b1, mk(1,0,0, 1,1,0, 0,0,0,0, 0,0,1)};
    tbl[1]  = '{1'b1, mk(1,0,0, 0,0,0, 1,2,1,0, 0,0,0)};
    tbl[2]  = '{1'b1, mk(1,0,0, 0,0,0, 0,0,0,0, 1,1,0)};
    tbl[3]  = '{1'b1, mk(1,0,0, 0,0,0, 0,1,1,1, 0,0,0)};
    tbl[4]  = '{1'b0, mk(1,0,1, 0,0,0, 0,0,0,0, 1,0,0)};
    tbl[5]  = '{1'b1, mk(1,0,1, 0,0,0, 0,1,1,1, 0,0,0)};
    tbl[6]  = '{1'b1, mk(1,0,2, 0,0,0, 0,0,0,0, 1,1,0)};
    tbl[7]  = '{1'b0, mk(1,0,2, 0,0,0, 0,1,1,1, 0,0,0)};
    tbl[8]  = '{1'b1, mk(1,0,3, 0,0,0, 0,0,0,0, 1,1,0)};
    tbl[9]  = '{1'b1, mk(1,0,3, 0,0,0, 0,1,1,1, 0,0,0)};
    tbl[10] = '{1'b1, mk(1,0,0, 0,0,1, 0,0,0,0, 0,0,0)};
    tbl[11] = '{1'b1, mk(1,1,0, 0,0,0, 0,0,0,0, 0,0,0)};
    tbl[12] = '{1'b1, ZERO};

    bus.start = 1'b1;
    bus.abort = 1'b0;
    bus.flag  = 1'b0;
    rst_n     = 1'b0;

    // Reset held two edges with start high
    cycle();
    cycle();
    chk_ctl("t1_reset", dut_ctl(), ZERO);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    cycle();
    chk_ctl("t1_after_release", dut_ctl(), ZERO);

    // Full operation, cycle by cycle
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      bus.flag = tbl[i].flag;
      #1;
      chk_ctl($sformatf("t2_cycle%0d", i + 1), dut_ctl(), tbl[i].exp);
      cycle();
    end
    bus.flag = 1'b0;

    // Start held high: LOAD every 13 cycles, one done per op
    cnt = 0;
    bus.start = 1'b1;
    for (int c = 1; c <= 39; c++) begin
      cycle();
      if (bus.en_a) loads.push_back(c);
      if (bus.done) cnt++;
    end
    bus.start = 1'b0;
    chk("t3_load_count", loads.size(), 3);
    if (loads.size() >= 3) begin
      chk("t3_first_load", loads[0], 1);
      chk("t3_period_a", loads[1] - loads[0], 13);
      chk("t3_period_b", loads[2] - loads[1], 13);
    end
    chk("t3_done_count", cnt, 3);
    cycle();
    chk("t3_idle_after", int'(bus.busy), 0);

    // Start pulsed mid-operation is ignored
    run_op(5, 0, done_cyc, dpo_cyc, extra_loads);
    chk("t4_done_cycle", done_cyc, 12);
    chk("t4_dpo_cycle", dpo_cyc, 11);
    chk("t4_extra_loads", extra_loads, 0);

    // Abort in SHIFT with iter=2
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    for (int c = 2; c <= 8; c++) cycle();
    chk("t5_iter_at_abort", int'(bus.iter), 2);
    chk("t5_sr_ctl_at_abort", int'(bus.sr_ctl), 1);
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
    chk_ctl("t5_after_abort", dut_ctl(), ZERO);
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.en_dpo || bus.done || bus.busy) cnt++;
      cycle();
    end
    chk("t5_no_store_done", cnt, 0);

    // Abort in LOAD and in STORE: no done
    run_op(0, 1, done_cyc, dpo_cyc, extra_loads);
    chk("t5_abort_load_done", done_cyc, 0);
    chk("t5_abort_load_dpo", dpo_cyc, 0);
    run_op(0, 11, done_cyc, dpo_cyc, extra_loads);
    chk("t5_abort_store_done", done_cyc, 0);
    chk("t5_abort_store_dpo", dpo_cyc, 11);

    // Abort in DONE is ignored
    run_op(0, 12, done_cyc, dpo_cyc, extra_loads);
    chk("t5_abort_done_cycle", done_cyc, 12);

    // Reset during ADD1, then a fresh operation
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    for (int c = 2; c <= 5; c++) cycle();
    chk("t6_in_add1_alu", int'(bus.alu_op), 1);
    chk("t6_in_add1_iter", int'(bus.iter), 1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk_ctl("t6_after_reset", dut_ctl(), ZERO);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.done || bus.en_dpo || bus.busy) cnt++;
      cycle();
    end
    chk("t6_quiet_after_reset", cnt, 0);
    run_op(0, 0, done_cyc, dpo_cyc, extra_loads);
    chk("t6_restart_done", done_cyc, 12);
    chk("t6_restart_dpo", dpo_cyc, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
